// File: rtl/sequencer.sv
// Multi-cycle control sequencer for a 16-bit accumulator-less core.
// Fetch, decode, execute, memory and writeback driven from ir.
module sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [2:0]  src_sel,
  output logic [2:0]  dst_sel,
  output logic        reg_out_en,
  output logic        reg_in_en,
  output logic        pc_inc,
  output logic        alu_en,
  output logic [2:0]  alu_op,
  output logic        halted,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_t;

  state_t      cur;
  state_t      nxt;
  logic [15:0] ir;
  logic        ir_ld;

  logic [3:0]  opc;
  logic [2:0]  f_dst;
  logic [2:0]  f_src;
  logic [2:0]  f_aop;
  logic        is_mov;
  logic        is_alu;
  logic        is_ld;
  logic        is_st;
  logic        is_hlt;
  logic        unused_ir;

  assign opc       = ir[15:12];
  assign f_dst     = ir[11:9];
  assign f_src     = ir[8:6];
  assign f_aop     = ir[2:0];
  assign unused_ir = ^ir[5:3];

  assign is_mov = (opc == 4'h1);
  assign is_alu = (opc == 4'h2);
  assign is_ld  = (opc == 4'h3);
  assign is_st  = (opc == 4'h4);
  assign is_hlt = (opc == 4'hF);

  assign state = cur;

  // State and instruction register; reset abandons any transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur <= S_FETCH;
      ir  <= 16'h0000;
    end else begin
      cur <= nxt;
      if (ir_ld) ir <= mem_rdata;
    end
  end

  // Next-state and control decode; everything is gated off in reset.
  always_comb begin
    nxt        = cur;
    ir_ld      = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    src_sel    = 3'd0;
    dst_sel    = 3'd0;
    reg_out_en = 1'b0;
    reg_in_en  = 1'b0;
    pc_inc     = 1'b0;
    alu_en     = 1'b0;
    alu_op     = 3'd0;
    halted     = 1'b0;
    case (cur)
      S_FETCH: begin
        mem_req    = 1'b1;
        reg_out_en = 1'b1;
        if (mem_ack) begin
          ir_ld  = 1'b1;
          pc_inc = 1'b1;
          nxt    = S_DECODE;
        end
      end
      S_DECODE: nxt = S_EXEC;
      S_EXEC: begin
        unique case (1'b1)
          is_mov: begin
            src_sel    = f_src;
            dst_sel    = f_dst;
            reg_out_en = 1'b1;
            reg_in_en  = 1'b1;
            nxt        = S_FETCH;
          end
          is_alu: begin
            src_sel   = f_src;
            dst_sel   = f_dst;
            alu_en    = 1'b1;
            alu_op    = f_aop;
            reg_in_en = 1'b1;
            nxt       = S_FETCH;
          end
          is_ld, is_st: nxt = S_MEM;
          is_hlt:       nxt = S_HALT;
          default:      nxt = S_FETCH;
        endcase
      end
      S_MEM: begin
        mem_req    = 1'b1;
        src_sel    = f_src;
        reg_out_en = 1'b1;
        if (is_st) begin
          mem_we  = 1'b1;
          dst_sel = f_dst;
        end
        if (mem_ack) nxt = is_st ? S_FETCH : S_WB;
      end
      S_WB: begin
        dst_sel   = f_dst;
        reg_in_en = 1'b1;
        nxt       = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
        nxt    = S_HALT;
      end
      default: nxt = S_FETCH;
    endcase
    if (rst) begin
      ir_ld      = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      src_sel    = 3'd0;
      dst_sel    = 3'd0;
      reg_out_en = 1'b0;
      reg_in_en  = 1'b0;
      pc_inc     = 1'b0;
      alu_en     = 1'b0;
      alu_op     = 3'd0;
    end
  end

endmodule

// File: tb/tb_sequencer.sv
// Testbench for sequencer: per-instruction cycle scripts built
// from the instruction set rules, driven with random timing.
module tb_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] mem_rdata = 16'h0000;
  logic        mem_ack = 1'b0;
  logic        mem_req;
  logic        mem_we;
  logic [2:0]  src_sel;
  logic [2:0]  dst_sel;
  logic        reg_out_en;
  logic        reg_in_en;
  logic        pc_inc;
  logic        alu_en;
  logic [2:0]  alu_op;
  logic        halted;
  logic [2:0]  state;

  always #5 clk = ~clk;

  sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .src_sel    (src_sel),
    .dst_sel    (dst_sel),
    .reg_out_en (reg_out_en),
    .reg_in_en  (reg_in_en),
    .pc_inc     (pc_inc),
    .alu_en     (alu_en),
    .alu_op     (alu_op),
    .halted     (halted),
    .state      (state)
  );

  typedef struct packed {
    logic       req;
    logic       we;
    logic [2:0] src;
    logic [2:0] dst;
    logic       roe;
    logic       rie;
    logic       pci;
    logic       alu;
    logic [2:0] aop;
    logic       hlt;
    logic [2:0] st;
  } vec_t;

  typedef struct {
    logic        ack;
    logic [15:0] rd;
    logic [15:0] w;
    vec_t        e;
  } step_t;

  vec_t  obs;
  step_t q[$];
  int    total = 0;
  int    bad = 0;

  assign obs = {mem_req, mem_we, src_sel, dst_sel, reg_out_en,
                reg_in_en, pc_inc, alu_en, alu_op, halted, state};

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic vec_t ctl_mask();
    vec_t m;
    m = '1;
    m.st = 3'd0;
    m.hlt = 1'b0;
    return m;
  endfunction

  function automatic void push(logic a, logic [15:0] d,
                               logic [15:0] w, vec_t e);
    step_t s;
    s.ack = a;
    s.rd  = d;
    s.w   = w;
    s.e   = e;
    q.push_back(s);
  endfunction

  // Expected cycle script for one instruction, from the ISA rules.
  function automatic void plan(logic [15:0] w, int fd, int md,
                               int halt_n);
    logic [3:0] op;
    logic [2:0] d;
    logic [2:0] s;
    vec_t e;
    op = w[15:12];
    d  = w[11:9];
    s  = w[8:6];
    e = '0;
    e.req = 1'b1;
    e.roe = 1'b1;
    repeat (fd) push(1'b0, 16'($urandom), w, e);
    e.pci = 1'b1;
    push(1'b1, w, w, e);
    e = '0;
    e.st = 3'd1;
    push(rbit(), 16'($urandom), w, e);
    e = '0;
    e.st = 3'd2;
    if (op == 4'h1) begin
      e.src = s; e.dst = d; e.roe = 1'b1; e.rie = 1'b1;
      push(rbit(), 16'($urandom), w, e);
    end else if (op == 4'h2) begin
      e.src = s; e.dst = d; e.alu = 1'b1;
      e.aop = w[2:0]; e.rie = 1'b1;
      push(rbit(), 16'($urandom), w, e);
    end else if (op == 4'h3 || op == 4'h4) begin
      push(rbit(), 16'($urandom), w, e);
      e = '0;
      e.st = 3'd3; e.req = 1'b1; e.src = s; e.roe = 1'b1;
      if (op == 4'h4) begin
        e.we = 1'b1; e.dst = d;
      end
      repeat (md) push(1'b0, 16'($urandom), w, e);
      push(1'b1, 16'($urandom), w, e);
      if (op == 4'h3) begin
        e = '0;
        e.st = 3'd4; e.dst = d; e.rie = 1'b1;
        push(rbit(), 16'($urandom), w, e);
      end
    end else if (op == 4'hF) begin
      push(rbit(), 16'($urandom), w, e);
      e.st = 3'd7;
      e.hlt = 1'b1;
      repeat (halt_n) push(1'b1, 16'($urandom), w, e);
    end else begin
      push(rbit(), 16'($urandom), w, e);
    end
  endfunction

  task automatic tick(input logic r, input logic a,
                      input logic [15:0] d);
    @(negedge clk);
    rst = r;
    mem_ack = a;
    mem_rdata = d;
    #1;
  endtask

  function automatic logic [15:0] rand_instr(logic allow_mem);
    logic [3:0] op;
    logic [15:0] w;
    op = 4'($urandom_range(0, 14));
    if (!allow_mem && (op == 4'h3 || op == 4'h4)) op = 4'h1;
    w = 16'($urandom);
    w[15:12] = op;
    return w;
  endfunction

  task automatic test_reset(input int hold);
    vec_t f;
    tick(1'b1, rbit(), 16'($urandom));
    total++;
    if ((obs & ctl_mask()) !== '0) begin
      bad++;
      $display("FAIL reset_ctl got=%h exp=%h", obs & ctl_mask(), 19'h0);
    end
    repeat (hold) begin
      tick(1'b1, rbit(), 16'($urandom));
      total++;
      if (obs !== '0) begin
        bad++;
        $display("FAIL reset_hold got=%h exp=%h", obs, 19'h0);
      end
    end
    f = '0;
    f.req = 1'b1;
    f.roe = 1'b1;
    tick(1'b0, 1'b0, 16'($urandom));
    total++;
    if (obs !== f) begin
      bad++;
      $display("FAIL reset_release got=%h exp=%h", obs, f);
    end
  endtask

  task automatic test_directed();
    plan(16'h1280, 0, 0, 0);
    plan(16'h3440, 1, 3, 0);
    plan(16'h4A00, 2, 2, 0);
    plan(16'h2283, 0, 0, 0);
    plan(16'h1200, 0, 0, 0);
    plan(16'h7000, 0, 0, 0);
    plan(16'h0000, 1, 0, 0);
    while (q.size() > 0) begin
      step_t s;
      s = q.pop_front();
      tick(1'b0, s.ack, s.rd);
      total++;
      if (obs !== s.e) begin
        bad++;
        $display("FAIL directed ir=%h got=%h exp=%h", s.w, obs, s.e);
      end
    end
  endtask

  task automatic test_random();
    repeat (150) begin
      plan(rand_instr(1'b1), $urandom_range(0, 3),
           $urandom_range(0, 4), 0);
      while (q.size() > 0) begin
        step_t s;
        s = q.pop_front();
        tick(1'b0, s.ack, s.rd);
        total++;
        if (obs !== s.e) begin
          bad++;
          $display("FAIL random ir=%h got=%h exp=%h", s.w, obs, s.e);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    repeat (60) plan(rand_instr(1'b1), 0, 0, 0);
    while (q.size() > 0) begin
      step_t s;
      s = q.pop_front();
      tick(1'b0, s.ack, s.rd);
      total++;
      if (obs !== s.e) begin
        bad++;
        $display("FAIL b2b ir=%h got=%h exp=%h", s.w, obs, s.e);
      end
    end
  endtask

  task automatic test_halt();
    plan(16'h1280, 0, 0, 0);
    plan(16'hF000, 1, 0, 10);
    while (q.size() > 0) begin
      step_t s;
      s = q.pop_front();
      tick(1'b0, s.ack, s.rd);
      total++;
      if (obs !== s.e) begin
        bad++;
        $display("FAIL halt ir=%h got=%h exp=%h", s.w, obs, s.e);
      end
    end
    test_reset(1);
  endtask

  task automatic test_rst_mid_mem();
    plan(16'h3440, 0, 5, 0);
    repeat (5) begin
      step_t s;
      s = q.pop_front();
      tick(1'b0, s.ack, s.rd);
      total++;
      if (obs !== s.e) begin
        bad++;
        $display("FAIL midmem ir=%h got=%h exp=%h", s.w, obs, s.e);
      end
    end
    q.delete();
    test_reset(2);
    plan(16'h7000, 1, 0, 0);
    plan(16'h1280, 0, 0, 0);
    while (q.size() > 0) begin
      step_t s;
      s = q.pop_front();
      tick(1'b0, s.ack, s.rd);
      total++;
      if (obs !== s.e) begin
        bad++;
        $display("FAIL after_rst ir=%h got=%h exp=%h", s.w, obs, s.e);
      end
    end
  endtask

  initial begin
    test_reset(2);
    test_directed();
    test_random();
    test_back_to_back();
    test_halt();
    test_rst_mid_mem();
    test_directed();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sequencer.md
SEQUENCER -- requirements
Module: sequencer

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-002 SHALL have port rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-003 SHALL have port mem_rdata  input  16  instruction/data word from memory bus.
REQ-004 SHALL have port mem_ack  input  1  memory transfer complete; valid only while mem_req=1.
REQ-005 SHALL have port mem_req  output  1  memory transfer request.
REQ-006 SHALL have port mem_we  output  1  1=store, 0=load/fetch; meaningful only with mem_req.
REQ-007 SHALL have port src_sel  output  3  register-file source select.
REQ-008 SHALL have port dst_sel  output  3  register-file destination select.
REQ-009 SHALL have port reg_out_en  output  1  drive selected source register onto bus.
REQ-010 SHALL have port reg_in_en  output  1  write bus into dst_sel register.
REQ-011 SHALL have port pc_inc  output  1  increment r0 (PC) by one.
REQ-012 SHALL have port alu_en  output  1  ALU result drives bus.
REQ-013 SHALL have port alu_op  output  3  ALU operation code.
REQ-014 SHALL have port halted  output  1  core stopped.
REQ-015 SHALL have port state  output  3  current FSM state, for debug.

Function
REQ-016 SHALL decode instruction register ir as: ir[15:12] opcode, ir[11:9] dst, ir[8:6] src, ir[2:0] alu_op.
REQ-017 SHALL encode states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7.
REQ-018 SHALL implement opcodes 0 NOP, 1 MOV, 2 ALU, 3 LD, 4 ST, F HLT; all other opcodes SHALL execute as NOP.
REQ-019 FETCH: mem_req=1, mem_we=0, src_sel=0, reg_out_en=1 (PC as address); hold until mem_ack.
REQ-020 FETCH with mem_ack=1: latch mem_rdata into ir, assert pc_inc for exactly that cycle, next state DECODE.
REQ-021 DECODE: all control outputs 0, next state EXEC (one-cycle decode bubble).
REQ-022 EXEC NOP: no control asserted, next FETCH.
REQ-023 EXEC MOV: src_sel=src, dst_sel=dst, reg_out_en=1, reg_in_en=1 for one cycle, next FETCH.
REQ-024 EXEC ALU: src_sel=src, dst_sel=dst, alu_en=1, alu_op=ir[2:0], reg_in_en=1 for one cycle, next FETCH.
REQ-025 EXEC LD or ST: no control asserted, next MEM.
REQ-026 MEM LD: mem_req=1, mem_we=0, src_sel=src, reg_out_en=1; hold until mem_ack, then WB.
REQ-027 MEM ST: mem_req=1, mem_we=1, src_sel=src, dst_sel=dst, reg_out_en=1; hold until mem_ack, then FETCH.
REQ-028 WB: dst_sel=dst, reg_in_en=1 for one cycle (bus carries loaded word), next FETCH.
REQ-029 EXEC HLT: next HALT; HALT SHALL hold halted=1, all other controls 0, and leave HALT only on rst.
REQ-030 dst=0 on MOV/ALU/LD SHALL write PC (jump); no pc_inc SHALL be asserted in that instruction after FETCH.
REQ-031 mem_ack while mem_req=0 SHALL be ignored.
REQ-032 reg_in_en and pc_inc SHALL never be asserted in the same cycle.
REQ-033 mem_req SHALL remain asserted with stable mem_we/src_sel every cycle until mem_ack.
REQ-034 All outputs SHALL be registered-state decodes (Moore); no output depends combinationally on mem_ack except pc_inc in FETCH.

Reset
REQ-035 rst=1 at any posedge SHALL force state=FETCH, ir=16'h0000, halted=0 next cycle, abandoning any pending memory transfer.
REQ-036 While rst=1 all control outputs (mem_req, mem_we, reg_out_en, reg_in_en, pc_inc, alu_en) SHALL be 0, src_sel=dst_sel=alu_op=0.
REQ-037 First cycle after rst deasserts SHALL be FETCH with mem_req=1.

Verification
REQ-038 Reset then mem_ack=1 immediately with rdata=16'h1280 (MOV r1<-r2) -> FETCH, pc_inc 1 cycle, DECODE, EXEC with src_sel=2 dst_sel=1 reg_in_en=reg_out_en=1, FETCH; 4 cycles total.
REQ-039 LD 16'h3440 (r2<-mem[r1]) with mem_ack delayed 3 cycles in MEM -> mem_req held 3 cycles, src_sel=1; WB dst_sel=2 reg_in_en=1 one cycle.
REQ-040 ST 16'h4A00 (mem[r5]<-r0) -> MEM mem_we=1 src_sel=0 dst_sel=5 until ack; no reg_in_en issued.
REQ-041 ALU 16'h2283 -> EXEC alu_en=1 alu_op=3 src_sel=2 dst_sel=1 reg_in_en=1.
REQ-042 HLT 16'hF000 then 10 cycles of mem_ack=1 -> halted=1, mem_req=0 throughout; rst -> FETCH, halted=0.
REQ-043 rst asserted mid-MEM with mem_req=1 -> next cycle state=FETCH, all controls 0 while rst=1; opcode 16'h7000 executes as NOP.
